// File: rtl/ppu_pkg.sv
// Shared constants and types for the PPU CPU-facing register read port.
// Register indices, frame timing events, status bit positions and palette decode.
package ppu_pkg;

  // CPU register indices ($2000 + ain)
  localparam logic [2:0] PPUCTRL   = 3'd0;
  localparam logic [2:0] PPUSTATUS = 3'd2;
  localparam logic [2:0] OAMDATA   = 3'd4;
  localparam logic [2:0] PPUDATA   = 3'd7;

  // Frame timing: flags change on dot 1 of these scanlines
  localparam logic [8:0] VBLANK_LINE    = 9'd241;
  localparam logic [8:0] PRERENDER_LINE = 9'd261;
  localparam logic [8:0] FLAG_DOT       = 9'd1;

  // PPUSTATUS bit positions
  localparam int STATUS_VBLANK_BIT  = 7;
  localparam int STATUS_SPRITE0_BIT = 6;
  localparam int STATUS_OVF_BIT     = 5;

  // Mask of the PPUSTATUS bits driven by flags; the rest come from open bus
  localparam logic [7:0] STATUS_DRIVEN_MASK = 8'hE0;
  // Palette reads drive only the low 6 bits
  localparam logic [7:0] PALETTE_DRIVEN_MASK = 8'h3F;

  localparam logic [5:0] PALETTE_PAGE = 6'h3F;

  // Decay counter width; DECAY_CYCLES must fit in it
  localparam int DECAY_W = 22;

  // A CPU bus drive: which bits the PPU actually drives, and their values
  typedef struct packed {
    logic [7:0] mask;
    logic [7:0] value;
  } bus_drive_t;

  function automatic logic is_palette_page(input logic [5:0] page);
    return page == PALETTE_PAGE;
  endfunction

endpackage

// File: rtl/open_bus_latch.sv
// CPU open-bus latch: refreshed by every driven bus bit, decays to zero after
// DECAY_CYCLES ce ticks without a refresh.
module open_bus_latch
  import ppu_pkg::*;
#(
  parameter int unsigned DECAY_CYCLES = 3000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       refresh,
  input  logic [7:0] drive_mask,
  input  logic [7:0] drive_value,
  output logic [7:0] value
);

  localparam logic [DECAY_W-1:0] DECAY_LIMIT = DECAY_W'(DECAY_CYCLES);

  logic [DECAY_W-1:0] decay_cnt;
  logic [DECAY_W-1:0] cnt_next;

  // Saturates at the limit so the latch stays zero until the next refresh
  always_comb begin
    cnt_next = (decay_cnt == DECAY_LIMIT) ? decay_cnt : decay_cnt + DECAY_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value     <= 8'h00;
      decay_cnt <= '0;
    end else if (ce) begin
      if (refresh) begin
        value     <= (value & ~drive_mask) | (drive_value & drive_mask);
        decay_cnt <= '0;
      end else begin
        decay_cnt <= cnt_next;
        if (cnt_next == DECAY_LIMIT) value <= 8'h00;
      end
    end
  end

endmodule

// File: rtl/ppu_read_port.sv
// PPU CPU-side register read port: status flags, NMI generation, PPUDATA read
// buffer and the read data mux with open-bus fill for undriven bits.
module ppu_read_port
  import ppu_pkg::*;
#(
  parameter int unsigned DECAY_CYCLES = 3000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic [2:0]  ain,
  input  logic [7:0]  din,
  input  logic        read,
  input  logic        write,
  input  logic [8:0]  scanline,
  input  logic [8:0]  cycle,
  input  logic        sprite0_hit_in,
  input  logic        sprite_ovf_in,
  input  logic [13:0] vram_addr,
  input  logic [7:0]  vram_din,
  input  logic [5:0]  palette_din,
  input  logic [7:0]  oam_din,
  output logic [7:0]  dout,
  output logic        nmi
);

  logic       nmi_enable;
  logic       vblank_flag;
  logic       sprite0_flag;
  logic       ovf_flag;
  logic [7:0] read_buf;
  logic [7:0] openbus;

  logic       vblank_set;
  logic       frame_clear;
  logic       status_read;
  logic       palette_sel;
  bus_drive_t drv;

  // Only the page bits select palette space; the low byte is decoded outside
  logic unused_addr_bits;
  assign unused_addr_bits = ^vram_addr[7:0];

  assign vblank_set  = (scanline == VBLANK_LINE)    && (cycle == FLAG_DOT);
  assign frame_clear = (scanline == PRERENDER_LINE) && (cycle == FLAG_DOT);
  assign status_read = read && (ain == PPUSTATUS);
  assign palette_sel = is_palette_page(vram_addr[13:8]);

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    drv.mask  = 8'hFF;
    drv.value = openbus;
    unique case (ain)
      PPUSTATUS: begin
        drv.mask  = STATUS_DRIVEN_MASK;
        drv.value = openbus;
        drv.value[STATUS_VBLANK_BIT]  = vblank_flag;
        drv.value[STATUS_SPRITE0_BIT] = sprite0_flag;
        drv.value[STATUS_OVF_BIT]     = ovf_flag;
      end
      OAMDATA: drv.value = oam_din;
      PPUDATA: begin
        if (palette_sel) begin
          drv.mask  = PALETTE_DRIVEN_MASK;
          drv.value = {openbus[7:6], palette_din};
        end else begin
          drv.value = read_buf;
        end
      end
      default: drv.value = openbus;
    endcase
  end

  assign dout = reset_n ? drv.value : 8'h00;
  assign nmi  = nmi_enable & vblank_flag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nmi_enable <= 1'b0;
      read_buf   <= 8'h00;
    end else if (ce) begin
      if (write && (ain == PPUCTRL)) nmi_enable <= din[7];
      if (read && (ain == PPUDATA))  read_buf   <= vram_din;
    end
  end

  // A status read on the set dot suppresses vblank for the whole frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vblank_flag  <= 1'b0;
      sprite0_flag <= 1'b0;
      ovf_flag     <= 1'b0;
    end else if (ce) begin
      if (frame_clear) begin
        vblank_flag  <= 1'b0;
        sprite0_flag <= 1'b0;
        ovf_flag     <= 1'b0;
      end else begin
        if (vblank_set)       vblank_flag <= ~status_read;
        else if (status_read) vblank_flag <= 1'b0;
        if (sprite0_hit_in)   sprite0_flag <= 1'b1;
        if (sprite_ovf_in)    ovf_flag     <= 1'b1;
      end
    end
  end

  open_bus_latch #(
    .DECAY_CYCLES (DECAY_CYCLES)
  ) u_open_bus (
    .clk         (clk),
    .reset_n     (reset_n),
    .ce          (ce),
    .refresh     (read | write),
    .drive_mask  (write ? 8'hFF : drv.mask),
    .drive_value (write ? din   : drv.value),
    .value       (openbus)
  );

endmodule

// File: tb/tb_ppu_read_port.sv
// Self-checking bench for ppu_read_port: directed frame scenarios followed by
// randomized bus traffic against a behavioural model of the register port.
module tb_ppu_read_port;

  localparam int DECAY = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce;
  logic [2:0]  ain;
  logic [7:0]  din;
  logic        read;
  logic        write;
  logic [8:0]  scanline;
  logic [8:0]  cycle;
  logic        sprite0_hit_in;
  logic        sprite_ovf_in;
  logic [13:0] vram_addr;
  logic [7:0]  vram_din;
  logic [5:0]  palette_din;
  logic [7:0]  oam_din;
  logic [7:0]  dout;
  logic        nmi;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state
  bit         m_nmi_en, m_vb, m_s0, m_ovf;
  logic [7:0] m_rb, m_ob;
  int         m_age;
  logic [7:0] rd_sample;

  always #5 clk = ~clk;

  ppu_read_port #(.DECAY_CYCLES(DECAY)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ce             (ce),
    .ain            (ain),
    .din            (din),
    .read           (read),
    .write          (write),
    .scanline       (scanline),
    .cycle          (cycle),
    .sprite0_hit_in (sprite0_hit_in),
    .sprite_ovf_in  (sprite_ovf_in),
    .vram_addr      (vram_addr),
    .vram_din       (vram_din),
    .palette_din    (palette_din),
    .oam_din        (oam_din),
    .dout           (dout),
    .nmi            (nmi)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_dout();
    case (ain)
      3'd2:    return {m_vb, m_s0, m_ovf, m_ob[4:0]};
      3'd4:    return oam_din;
      3'd7:    return (vram_addr[13:8] == 6'h3F) ? {m_ob[7:6], palette_din} : m_rb;
      default: return m_ob;
    endcase
  endfunction

  task automatic model_reset();
    m_nmi_en = 0; m_vb = 0; m_s0 = 0; m_ovf = 0;
    m_rb = 8'h00; m_ob = 8'h00; m_age = 0;
  endtask

  task automatic model_edge();
    logic [7:0] d;
    bit at_set, at_clr, sr;
    if (!ce) return;
    d      = model_dout();
    at_set = (scanline == 9'd241) && (cycle == 9'd1);
    at_clr = (scanline == 9'd261) && (cycle == 9'd1);
    sr     = read && (ain == 3'd2);
    if (write) begin
      m_ob  = din;
      m_age = 0;
      if (ain == 3'd0) m_nmi_en = din[7];
    end else if (read) begin
      m_age = 0;
      if (ain == 3'd2)                                   m_ob[7:5] = d[7:5];
      else if (ain == 3'd7 && vram_addr[13:8] == 6'h3F)  m_ob[5:0] = d[5:0];
      else                                               m_ob = d;
      if (ain == 3'd7) m_rb = vram_din;
    end else begin
      if (m_age < DECAY) m_age++;
      if (m_age >= DECAY) m_ob = 8'h00;
    end
    if (at_clr) begin
      m_vb = 0; m_s0 = 0; m_ovf = 0;
    end else begin
      if (at_set)  m_vb = !sr;
      else if (sr) m_vb = 0;
      if (sprite0_hit_in) m_s0 = 1;
      if (sprite_ovf_in)  m_ovf = 1;
    end
  endtask

  // One clock: drive at negedge, check dout mid-cycle, update model at the
  // edge, check nmi just after it, return at the next negedge.
  task automatic tick(input bit rd, input bit wr, input logic [2:0] a, input logic [7:0] d);
    read = rd; write = wr; ain = a; din = d;
    #2;
    rd_sample = dout;
    if (rd && ce) check($sformatf("dout_a%0d", a), dout, model_dout());
    @(posedge clk);
    model_edge();
    #1;
    check("nmi", {7'b0, nmi}, {7'b0, m_nmi_en & m_vb});
    @(negedge clk);
    read = 0; write = 0; sprite0_hit_in = 0; sprite_ovf_in = 0;
  endtask

  task automatic place(input int sl, input int cy);
    scanline = 9'(sl);
    cycle    = 9'(cy);
  endtask

  task automatic do_reset();
    reset_n = 0;
    ain = 3'd4; oam_din = 8'hC3;
    #1;
    check("rst_dout", dout, 8'h00);
    check("rst_nmi", {7'b0, nmi}, 8'h00);
    model_reset();
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    ce = 1; ain = 0; din = 0; read = 0; write = 0;
    sprite0_hit_in = 0; sprite_ovf_in = 0;
    vram_addr = 14'h0000; vram_din = 8'h00; palette_din = 6'h00; oam_din = 8'h00;
    place(0, 0);
    reset_n = 0;
    @(negedge clk);
    do_reset();

    // vblank set, status read two ticks later, then read again
    place(241, 1); tick(0, 0, 0, 8'h00);
    place(241, 2); tick(0, 0, 0, 8'h00);
    place(241, 3); tick(1, 0, 2, 8'h00);
    check("vbl_first", {7'b0, rd_sample[7]}, 8'h01);
    tick(1, 0, 2, 8'h00);
    check("vbl_second", {7'b0, rd_sample[7]}, 8'h00);

    // nmi follows nmi_enable and vblank
    place(261, 1); tick(0, 0, 0, 8'h00);
    place(0, 0);   tick(0, 1, 0, 8'h80);
    place(241, 1); tick(0, 0, 0, 8'h00);
    check("nmi_rise", {7'b0, nmi}, 8'h01);
    place(241, 5); tick(1, 0, 2, 8'h00);
    check("nmi_fall", {7'b0, nmi}, 8'h00);

    // PPUDATA read buffer
    place(10, 10);
    do_reset();
    vram_addr = 14'h2000; vram_din = 8'hAB;
    tick(1, 0, 7, 8'h00);
    check("rbuf_old", rd_sample, 8'h00);
    tick(1, 0, 7, 8'h00);
    check("rbuf_new", rd_sample, 8'hAB);

    // palette read mixes open bus and loads the underlying byte
    tick(0, 1, 3, 8'hC0);
    vram_addr = 14'h3F05; palette_din = 6'h2A; vram_din = 8'h11;
    tick(1, 0, 7, 8'h00);
    check("pal_dout", rd_sample, 8'hEA);
    vram_addr = 14'h2000; vram_din = 8'h33;
    tick(1, 0, 7, 8'h00);
    check("pal_rbuf", rd_sample, 8'h11);

    // status read on the vblank set dot suppresses vblank and nmi for the frame
    tick(0, 1, 0, 8'h80);
    place(241, 1); tick(1, 0, 2, 8'h00);
    check("race_bit7", {7'b0, rd_sample[7]}, 8'h00);
    for (int sl = 241; sl <= 260; sl++) begin
      place(sl, 200); tick(0, 0, 0, 8'h00);
      check("race_nmi", {7'b0, nmi}, 8'h00);
    end
    place(261, 1); tick(0, 0, 0, 8'h00);

    // sprite flags: sticky, clear wins on the pre-render dot
    place(20, 30);
    sprite0_hit_in = 1; tick(0, 0, 0, 8'h00);
    sprite_ovf_in = 1;  tick(0, 0, 0, 8'h00);
    tick(1, 0, 2, 8'h00);
    check("spr_flags", rd_sample & 8'h60, 8'h60);
    place(261, 1); sprite0_hit_in = 1; sprite_ovf_in = 1; tick(0, 0, 0, 8'h00);
    place(0, 5); tick(1, 0, 2, 8'h00);
    check("spr_clear", rd_sample & 8'h60, 8'h00);

    // open-bus decay
    do_reset();
    tick(0, 1, 3, 8'h5A);
    repeat (10) tick(0, 0, 0, 8'h00);
    tick(1, 0, 5, 8'h00);
    check("ob_hold", rd_sample, 8'h5A);
    repeat (17) tick(0, 0, 0, 8'h00);
    tick(1, 0, 5, 8'h00);
    check("ob_decay", rd_sample, 8'h00);

    // mid-frame reset drops nmi immediately
    tick(0, 1, 0, 8'h80);
    place(241, 1); tick(0, 0, 0, 8'h00);
    check("pre_rst_nmi", {7'b0, nmi}, 8'h01);
    place(241, 9);
    #2;
    do_reset();
    place(250, 3); tick(1, 0, 2, 8'h00);
    check("post_rst_vbl", {7'b0, rd_sample[7]}, 8'h00);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      int op;
      int ev;
      logic [2:0] a;
      logic [7:0] d;
      ce = ($urandom_range(0, 7) != 0);
      ev = $urandom_range(0, 7);
      if (ev == 0)      place(241, 1);
      else if (ev == 1) place(261, 1);
      else              place($urandom_range(0, 261), $urandom_range(0, 340));
      sprite0_hit_in = ($urandom_range(0, 15) == 0);
      sprite_ovf_in  = ($urandom_range(0, 15) == 0);
      vram_addr   = $urandom_range(0, 1) ? (14'h3F00 | 14'($urandom_range(0, 255)))
                                         : 14'($urandom_range(0, 16383));
      vram_din    = 8'($urandom);
      palette_din = 6'($urandom);
      oam_din     = 8'($urandom);
      a  = 3'($urandom);
      d  = 8'($urandom);
      op = $urandom_range(0, 4);
      tick(op == 0, op == 1, a, d);
    end
    ce = 1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ppu_read_port.md
PPU_READ_PORT -- requirements
Module: ppu_read_port

Interface
REQ-001 SHALL have parameter DECAY_CYCLES, default 3000000: the number of ce ticks without a refresh before the open-bus latch decays to 0.
REQ-002 SHALL have these ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- ce  in  1  PPU clock enable; all state advances only when ce=1
- ain  in  3  CPU register index ($2000+ain)
- din  in  8  CPU write data
- read  in  1  CPU read strobe, one ce tick
- write  in  1  CPU write strobe, one ce tick
- scanline  in  9  current scanline, 0..261
- cycle  in  9  current dot, 0..340
- sprite0_hit_in  in  1  pulse that sets the sprite-0 flag
- sprite_ovf_in  in  1  pulse that sets the overflow flag
- vram_addr  in  14  current VRAM address (loopy value, low 14 bits)
- vram_din  in  8  VRAM byte at vram_addr
- palette_din  in  6  palette entry at vram_addr
- oam_din  in  8  OAM byte at the current OAM address
- dout  out  8  CPU read data
- nmi  out  1  NMI request, active-high level

Function
REQ-003 dout SHALL be combinational and valid in the same ce tick that read=1; all state updates SHALL occur on that tick's clock edge.
REQ-004 A write to ain=0 SHALL latch nmi_enable<=din[7].
REQ-005 vblank_flag SHALL set on the ce tick where scanline=241 and cycle=1.
REQ-006 vblank_flag, sprite0_flag and ovf_flag SHALL clear on the ce tick where scanline=261 and cycle=1.
REQ-007 sprite0_flag and ovf_flag SHALL set on their input pulses, stay sticky until the clear in REQ-006, and have the clear take priority on the same tick.
REQ-008 Read ain=2 SHALL return dout={vblank_flag, sprite0_flag, ovf_flag, openbus[4:0]} and clear vblank_flag.
REQ-009 Race rule: a read of ain=2 on the same tick vblank would set SHALL return bit7=0, leave vblank_flag clear for that frame, and keep nmi at 0.
REQ-010 Read ain=4 SHALL return oam_din.
REQ-011 Read ain=7 with vram_addr[13:8]!=6'h3F SHALL return read_buf and load read_buf<=vram_din.
REQ-012 Read ain=7 with vram_addr[13:8]==6'h3F SHALL return {openbus[7:6], palette_din} and load read_buf<=vram_din (the underlying nametable byte).
REQ-013 Read ain=0,1,3,5,6 SHALL return openbus[7:0].
REQ-014 Open-bus latch refresh: any write SHALL set openbus<=din.
REQ-015 Open-bus latch refresh: any read SHALL set openbus to the driven bits of dout, keeping latch bits not driven (ain=2 bits[4:0]; palette read bits[7:6]).
REQ-016 Every refresh SHALL reset the decay counter; once the counter reaches DECAY_CYCLES, openbus<=0 and the counter holds.
REQ-017 nmi SHALL equal nmi_enable AND vblank_flag.
- Setting nmi_enable while vblank_flag=1 raises nmi on the next tick.
- Clearing nmi_enable or reading ain=2 drops nmi on the next tick.
REQ-018 Decay counter SHALL be 22 bits and saturating; DECAY_CYCLES above 2^22-1 is illegal.

Reset
REQ-019 reset_n=0 SHALL asynchronously clear nmi_enable, vblank_flag, sprite0_flag, ovf_flag, read_buf, openbus and the decay counter; nmi=0 and dout=0 during reset.
REQ-020 Reset mid-frame SHALL take effect immediately; normal flag behaviour resumes at the next qualifying scanline/cycle event.

Structure
REQ-021 Shared package ppu_pkg SHALL hold:
- register index constants (PPUCTRL=0, PPUSTATUS=2, OAMDATA=4, PPUDATA=7)
- VBLANK_LINE=241, PRERENDER_LINE=261
- status bit positions
- PALETTE_PAGE=6'h3F
REQ-022 The open-bus latch plus decay counter SHALL be a sub-module named open_bus_latch; the flag logic and read mux SHALL stay in ppu_read_port.

Verification
REQ-023 Step to scanline 241 cycle 1, then read ain=2 two ticks later -> dout[7]=1; the next ain=2 read gives dout[7]=0.
REQ-024 Write ain=0 din=8'h80, step to vblank set -> nmi=1 on the next tick; read ain=2 -> nmi=0 on the next tick.
REQ-025 With vram_addr=14'h2000 and vram_din=8'hAB, read ain=7 twice -> first dout=old buffer (0 after reset), second dout=8'hAB.
REQ-026 With vram_addr=14'h3F05, palette_din=6'h2A, openbus=8'hC0 and vram_din=8'h11 -> dout=8'hEA and read_buf=8'h11.
REQ-027 Read ain=2 exactly on scanline 241 cycle 1 with nmi_enable=1 -> dout[7]=0 and nmi stays 0 through scanline 260.
REQ-028 With DECAY_CYCLES=16, write ain=3 din=8'h5A, then read ain=5 after 10 ticks -> 8'h5A; after 17 idle ticks -> 8'h00.
